// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : uart_pkg                                                 |
// | Description : Shared types and constants for the UART blocks: FSM      |
// |               state encoding, status-word bit positions and the        |
// |               default bit period.                                      |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Plain-vector aliases so state registers stay simple logic vectors.
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_START = START;
    localparam logic [1:0] ST_DATA  = DATA;
    localparam logic [1:0] ST_STOP  = STOP;

    // Bit positions inside the status word.
    localparam int STATUS_BUSY  = 0;
    localparam int STATUS_FULL  = 1;
    localparam int STATUS_EMPTY = 2;
    localparam int STATUS_OVF   = 3;

    // 50 MHz / 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_tx_mmio_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface   : uart_tx_mmio_if                                          |
// | Description : Store/status port of the memory-mapped TX UART.          |
// |   wr_en   : one-cycle store strobe from the address decoder            |
// |   wr_data : store data, low byte is transmitted                        |
// |   tx      : serial line, idle high                                     |
// |   status  : {28'b0, overflow, empty, full, busy} to the read mux       |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
interface uart_tx_mmio_if;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        tx;
    logic [31:0] status;

    modport master (output wr_en, output wr_data, input tx, input status);
    modport slave  (input wr_en, input wr_data, output tx, output status);
endinterface : uart_tx_mmio_if
`default_nettype wire

// File: rtl/uart_tx_mmio_sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : sync_fifo                                                |
// | Description : Single-clock FIFO, power-of-two depth, first-word        |
// |               fall-through read data.                                  |
// |   push/din  : write when not full (full sampled before the edge)       |
// |   pop/dout  : dout is the head entry; pop advances when not empty      |
// |   full/empty/count : occupancy 0..DEPTH                                |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         din,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         dout,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : uart_tx_mmio                                             |
// | Description : Memory-mapped 8N1 UART transmitter. Stores push bytes    |
// |               into a FIFO; a baud FSM shifts them out LSB first.       |
// |   clk   : system clock                                                 |
// |   rst_n : asynchronous active-low reset                                |
// |   bus   : store strobe/data in, tx line and status word out            |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    uart_tx_mmio_if.slave bus
);
    localparam int BW = $clog2(CLKS_PER_BIT);

    logic [1:0]              state_q, state_d;
    logic [BW-1:0]           baud_q, baud_d;
    logic [2:0]              bit_q, bit_d;
    logic [7:0]              shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    overflow_q, overflow_d;

    logic                    fifo_pop;
    logic                    fifo_full, fifo_empty;
    logic [7:0]              fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;
    logic                    wr_data_hi_unused;
    logic                    baud_last;
    logic [31:0]             status_w;

    assign wr_data_hi_unused = ^bus.wr_data[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.wr_en),
        .din   (bus.wr_data[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

    // tx_d is the line level for the cycle following the edge, so every
    // transition also picks the level of the state being entered.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    state_d  = ST_START;
                    tx_d     = 1'b0;
                end
            end
            ST_START: begin
                baud_d = baud_q + BW'(1);
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                baud_d = baud_q + BW'(1);
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                baud_d = baud_q + BW'(1);
                if (baud_last) begin
                    baud_d = '0;
                    // Chain straight into the next start bit: no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        state_d  = ST_START;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Full is the pre-edge value, so a pop in the same cycle cannot save it.
    assign overflow_d = overflow_q | (bus.wr_en & fifo_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        status_w               = '0;
        status_w[STATUS_BUSY]  = (state_q != ST_IDLE);
        status_w[STATUS_FULL]  = fifo_full;
        status_w[STATUS_EMPTY] = fifo_empty;
        status_w[STATUS_OVF]   = overflow_q;
    end

    assign bus.tx     = tx_q;
    assign bus.status = status_w;
endmodule : uart_tx_mmio
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_uart_tx_mmio                                          |
// | Description : Self-checking bench for uart_tx_mmio with a frame-level  |
// |               reference model and directed byte sequences.             |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module tb_uart_tx_mmio;
    localparam int C = 4;
    localparam int D = 4;
    localparam int HIST = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic [7:0] mq[$];
    int         mcyc   = -1;      // cycle within current frame, -1 = idle
    logic [9:0] mframe = '1;      // {stop, data, start}; index = bit slot
    logic       movf   = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                mcyc = -1;
                movf = 1'b0;
            end else begin
                logic       full_pre;
                logic       w;
                logic [7:0] d;
                full_pre = (mq.size() == D);
                w        = bus.wr_en;
                d        = bus.wr_data[7:0];
                if ((mcyc < 0 || mcyc == 10*C-1) && mq.size() > 0) begin
                    mframe = {1'b1, mq.pop_front(), 1'b0};
                    mcyc   = 0;
                end else if (mcyc == 10*C-1) begin
                    mcyc = -1;
                end else if (mcyc >= 0) begin
                    mcyc = mcyc + 1;
                end
                if (w) begin
                    if (full_pre) movf = 1'b1;
                    else          mq.push_back(d);
                end
            end
        end
    end

    function automatic logic m_tx();
        if (mcyc < 0) return 1'b1;
        return mframe[mcyc / C];
    endfunction

    function automatic logic [31:0] m_status();
        return {28'b0, movf, mq.size() == 0, mq.size() == D, mcyc >= 0};
    endfunction

    // ---------------- cycle counter, history and compare ----------------
    int         cyc_n = 0;
    logic       tx_hist [HIST];
    logic [31:0] st_hist [HIST];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    initial begin
        forever begin
            @(negedge clk);
            chk("tx_vs_model", 32'(bus.tx), 32'(m_tx()));
            chk("status_vs_model", bus.status, m_status());
            if (cyc_n < HIST) begin
                tx_hist[cyc_n] = bus.tx;
                st_hist[cyc_n] = bus.status;
            end
        end
    end

    // ---------------- helpers ----------------
    logic [7:0] dec[$];

    task automatic decode(input int s, input int n);
        int i;
        logic [7:0] b;
        dec.delete();
        i = s;
        while (i + 10*C <= s + n) begin
            if (tx_hist[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = tx_hist[i + C/2 + (k+1)*C];
                dec.push_back(b);
                i = i + 10*C;
            end else begin
                i = i + 1;
            end
        end
    endtask

    function automatic int count_low(input int s, input int n);
        int c = 0;
        for (int i = s; i < s + n; i++) if (tx_hist[i] == 1'b0) c++;
        return c;
    endfunction

    function automatic int count_busy(input int s, input int n);
        int c = 0;
        for (int i = s; i < s + n; i++) if (st_hist[i][0]) c++;
        return c;
    endfunction

    task automatic wr(input logic [7:0] b);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_data = {24'hC0FFEE, b};
    endtask

    task automatic wr_done();
        @(negedge clk);
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
    endtask

    int a5_seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int mark;

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;

        // Reset only
        #1 rst_n = 1'b0;
        #1;
        chk("reset_tx", 32'(bus.tx), 32'd1);
        chk("reset_status", bus.status, 32'h4);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mark = cyc_n + 1;
        repeat (1000) @(negedge clk);
        chk("idle_1000_low_count", 32'(count_low(mark, 1000)), 32'd0);

        // Single byte 0xA5
        wr(8'hA5);
        mark = cyc_n + 1;
        wr_done();
        repeat (50) @(negedge clk);
        chk("a5_latency_idle", 32'(tx_hist[mark]), 32'd1);
        for (int k = 0; k < 10*C; k++)
            chk("a5_bit", 32'(tx_hist[mark + 1 + k]), 32'(a5_seq[k / C]));
        chk("a5_busy_cycles", 32'(count_busy(mark, 50)), 32'd40);
        chk("a5_status_after", st_hist[mark + 41], 32'h4);
        decode(mark, 50);
        chk("a5_decode_count", 32'(dec.size()), 32'd1);
        if (dec.size() >= 1) chk("a5_decode", 32'(dec[0]), 32'hA5);

        // Back-to-back 0x55, 0x0F
        wr(8'h55);
        mark = cyc_n + 1;
        wr(8'h0F);
        wr_done();
        repeat (90) @(negedge clk);
        chk("b2b_stop_end", 32'(tx_hist[mark + 40]), 32'd1);
        chk("b2b_second_start", 32'(tx_hist[mark + 41]), 32'd0);
        chk("b2b_busy_cycles", 32'(count_busy(mark, 92)), 32'd80);
        decode(mark, 92);
        chk("b2b_decode_count", 32'(dec.size()), 32'd2);
        if (dec.size() >= 2) begin
            chk("b2b_decode0", 32'(dec[0]), 32'h55);
            chk("b2b_decode1", 32'(dec[1]), 32'h0F);
        end

        // Overflow: six writes into a depth-4 FIFO
        wr(8'h01);
        mark = cyc_n + 1;
        for (int v = 2; v <= 6; v++) wr(8'(v));
        wr_done();
        chk("ovf_status_now", bus.status, 32'hB);
        repeat (230) @(negedge clk);
        decode(mark, 230);
        chk("ovf_decode_count", 32'(dec.size()), 32'd5);
        for (int k = 0; k < 5 && k < dec.size(); k++)
            chk("ovf_decode", 32'(dec[k]), 32'(k + 1));
        chk("ovf_status_final", bus.status, 32'hC);

        // Reset during DATA of 0x3C
        wr(8'h3C);
        wr_done();
        repeat (5) @(posedge clk);
        #1;
        chk("pre_reset_data_bit", 32'(bus.tx), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_reset_tx", 32'(bus.tx), 32'd1);
        chk("async_reset_status", bus.status, 32'h4);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        mark = cyc_n + 1;
        repeat (200) @(negedge clk);
        chk("post_reset_low_count", 32'(count_low(mark, 200)), 32'd0);
        chk("post_reset_status", bus.status, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule : tb_uart_tx_mmio
`default_nettype wire
